// File: rtl/muldiv_unit.sv
// Iterative MIPS HI/LO multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle, with sign fix-up before HI/LO are written.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH)+1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic             illegal,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] result
);
   localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13,
                          F_DIV  = 6'h1A, F_DIVU = 6'h1B;

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
   state_t state;

   logic [5:0]       op;
   logic [WIDTH-1:0] acc_hi, acc_lo, opb;
   logic [CNT_W-1:0] cnt;
   logic             neg_q, neg_r;

   logic             start_op, sgn, a_neg, b_neg, is_div;
   logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
   logic [WIDTH:0]   msum, dsh, ddiff;
   logic [2*WIDTH-1:0] prod_fix;

   assign start_op = (funct[5:2] == 4'b0110);
   assign sgn      = ~funct[0];
   assign a_neg    = sgn & a[WIDTH-1];
   assign b_neg    = sgn & b[WIDTH-1];
   assign a_mag    = a_neg ? -a : a;
   assign b_mag    = b_neg ? -b : b;
   assign is_div   = (op == F_DIV) || (op == F_DIVU);

   // acc_hi holds the running product high half / partial remainder,
   // acc_lo the multiplier being shifted out / quotient being shifted in.
   assign msum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
   assign dsh   = {acc_hi, acc_lo[WIDTH-1]};
   assign ddiff = dsh - {1'b0, opb};

   assign prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
   assign q_fix    = neg_q ? -acc_lo : acc_lo;
   assign r_fix    = neg_r ? -acc_hi : acc_hi;

   assign busy = (state != IDLE);

   always_comb begin
      result = '0;
      if (funct == F_MFHI)      result = hi;
      else if (funct == F_MFLO) result = lo;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         op          <= '0;
         acc_hi      <= '0;
         acc_lo      <= '0;
         opb         <= '0;
         cnt         <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         illegal     <= 1'b0;
      end else begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         illegal     <= 1'b0;
         case (state)
            IDLE: if (start) begin
               if (start_op) begin
                  op     <= funct;
                  acc_hi <= '0;
                  acc_lo <= a_mag;
                  opb    <= b_mag;
                  neg_q  <= a_neg ^ b_neg;
                  neg_r  <= a_neg;
                  cnt    <= '0;
                  state  <= RUN;
               end else if (funct == F_MTHI) begin
                  hi   <= a;
                  done <= 1'b1;
               end else if (funct == F_MTLO) begin
                  lo   <= a;
                  done <= 1'b1;
               end else begin
                  illegal <= 1'b1;
               end
            end
            RUN: begin
               if (is_div) begin
                  acc_hi <= ddiff[WIDTH] ? dsh[WIDTH-1:0] : ddiff[WIDTH-1:0];
                  acc_lo <= {acc_lo[WIDTH-2:0], ~ddiff[WIDTH]};
               end else begin
                  acc_hi <= msum[WIDTH:1];
                  acc_lo <= {msum[0], acc_lo[WIDTH-1:1]};
               end
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH-1)) state <= FIX;
            end
            FIX: begin
               if (is_div) begin
                  // Divide by zero leaves the dividend in the remainder, so hi = a falls out.
                  hi <= r_fix;
                  if (opb == '0) begin
                     lo          <= '1;
                     div_by_zero <= 1'b1;
                  end else begin
                     lo <= q_fix;
                  end
               end else begin
                  {hi, lo} <= prod_fix;
               end
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, hand sequences for MT/MF,
// illegal, ignored start and reset, then random ops against an arithmetic model.
module tb_muldiv_unit;
   localparam logic [5:0] MULT = 6'h18, MULTU = 6'h19, DIV = 6'h1A, DIVU = 6'h1B,
                          MFHI = 6'h10, MTHI = 6'h11, MFLO = 6'h12, MTLO = 6'h13;

   logic        clk = 0, rst = 1, start = 0;
   logic [5:0]  funct = 0;
   logic [31:0] a = 0, b = 0;
   logic        busy, done, div_by_zero, illegal;
   logic [31:0] hi, lo, result;

   int ncmp = 0, nfail = 0, ovl = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .funct(funct), .a(a), .b(b),
      .busy(busy), .done(done), .div_by_zero(div_by_zero), .illegal(illegal),
      .hi(hi), .lo(lo), .result(result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  f;
      logic [31:0] a, b, eh, el;
      logic        edz;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      ncmp++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   function automatic void model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] mh, output logic [31:0] ml, output logic mdz);
      longint sx, sy;
      logic [63:0] p, ux, uy;
      int qx, qy;
      mdz = 0; mh = 0; ml = 0;
      case (f)
         MULT: begin
            sx = longint'($signed(x)); sy = longint'($signed(y));
            p = 64'(sx * sy); {mh, ml} = p;
         end
         MULTU: begin
            ux = {32'b0, x}; uy = {32'b0, y};
            p = ux * uy; {mh, ml} = p;
         end
         DIV: begin
            if (y == 0) begin ml = '1; mh = x; mdz = 1; end
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin ml = x; mh = 0; end
            else begin
               qx = $signed(x); qy = $signed(y);
               ml = 32'(qx / qy); mh = 32'(qx % qy);
            end
         end
         DIVU: begin
            if (y == 0) begin ml = '1; mh = x; mdz = 1; end
            else begin ml = x / y; mh = x % y; end
         end
         default: ;
      endcase
   endfunction

   // Starts an op, follows it to done; optionally fires a second start at cycle inj.
   task automatic run_op(input logic [5:0] f, input logic [31:0] xa, input logic [31:0] xb,
                         input int inj, output logic [31:0] rh, output logic [31:0] rl,
                         output logic rdz, output int lat, output int nbusy);
      logic [31:0] hp;
      @(negedge clk);
      rst = 0; start = 1; funct = f; a = xa; b = xb; hp = hi;
      @(negedge clk);
      start = 0;
      lat = -1; nbusy = 0; rdz = 0; rh = 0; rl = 0;
      for (int k = 0; k < 100; k++) begin
         if (busy && (done || div_by_zero || illegal)) ovl++;
         if (busy) nbusy++;
         if (k == 3) chk("hi_hold_busy", hi, hp);
         if (done) begin
            lat = k; rh = hi; rl = lo; rdz = div_by_zero;
            break;
         end
         if (k == inj) begin start = 1; funct = DIVU; a = 32'h7; b = 32'h0; end
         else begin start = 0; funct = f; a = xa; b = xb; end
         @(negedge clk);
      end
      start = 0;
   endtask

   initial begin
      vec_t vt[8];
      logic [31:0] rh, rl, mh, ml, sv_hi, sv_lo;
      logic rdz, mdz;
      int lat, nb, extra;
      logic [5:0] rf;
      logic [31:0] ra, rb;

      vt[0] = '{MULT,  32'hFFFF_FFFD, 32'h7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 0};
      vt[1] = '{DIV,   32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0};
      vt[2] = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 0};
      vt[3] = '{DIVU,  32'h5,         32'h0,         32'h5,         32'hFFFF_FFFF, 1};
      vt[4] = '{DIV,   32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1};
      vt[5] = '{MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         0};
      vt[6] = '{DIVU,  32'hFFFF_FFFF, 32'hA,         32'h5,         32'h1999_9999, 0};
      vt[7] = '{DIV,   32'h7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD, 0};

      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_hilo", {hi, lo}, 0);
      chk("rst_flags", {illegal, div_by_zero}, 0);

      foreach (vt[i]) begin
         run_op(vt[i].f, vt[i].a, vt[i].b, -1, rh, rl, rdz, lat, nb);
         chk($sformatf("vec%0d_hi", i), rh, vt[i].eh);
         chk($sformatf("vec%0d_lo", i), rl, vt[i].el);
         chk($sformatf("vec%0d_dz", i), rdz, vt[i].edz);
         chk($sformatf("vec%0d_lat", i), lat, 33);
         chk($sformatf("vec%0d_busy", i), nb, 33);
      end

      // Second start while busy must be ignored.
      run_op(MULTU, 32'hFFFF_FFFF, 32'h2, 5, rh, rl, rdz, lat, nb);
      chk("ign_hi", rh, 32'h1);
      chk("ign_lo", rl, 32'hFFFF_FFFE);
      chk("ign_lat", lat, 33);
      extra = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) extra++;
      end
      chk("ign_no_second", extra, 0);

      // MTLO / MFLO / MTHI / illegal.
      start = 1; funct = MTLO; a = 32'h1234;
      @(negedge clk);
      chk("mtlo_lo", lo, 32'h1234);
      chk("mtlo_done", done, 1);
      chk("mtlo_busy", busy, 0);
      start = 0; funct = MFLO;
      #1 chk("mflo_result", result, 32'h1234);
      @(negedge clk);
      chk("mtlo_done_1cyc", done, 0);
      start = 1; funct = MTHI; a = 32'hCAFE_0001;
      @(negedge clk);
      start = 0; funct = MFHI;
      #1 chk("mfhi_result", result, 32'hCAFE_0001);
      sv_hi = 32'hCAFE_0001; sv_lo = 32'h1234;
      @(negedge clk);
      start = 1; funct = 6'h20;
      @(negedge clk);
      chk("ill_pulse", illegal, 1);
      chk("ill_nodone", {done, busy}, 0);
      chk("ill_hilo", {hi, lo}, {sv_hi, sv_lo});
      start = 0;
      @(negedge clk);
      chk("ill_1cyc", illegal, 0);
      start = 1; funct = MFHI;
      @(negedge clk);
      chk("mfhi_illegal", illegal, 1);
      start = 0;

      // Reset mid-multiply, then an immediate start after release.
      @(negedge clk);
      start = 1; funct = MULT; a = 32'h1111_1111; b = 32'h2222_2222;
      @(negedge clk);
      start = 0;
      repeat (9) @(negedge clk);
      rst = 1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_hilo", {hi, lo}, 0);
      chk("midrst_done", done, 0);
      run_op(MULT, 32'h3, 32'h4, -1, rh, rl, rdz, lat, nb);
      chk("post_rst_hi", rh, 0);
      chk("post_rst_lo", rl, 12);
      chk("post_rst_lat", lat, 33);

      // Random ops against the arithmetic model.
      for (int n = 0; n < 40; n++) begin
         rf = 6'h18 + 6'($urandom_range(0, 3));
         ra = $urandom;
         case ($urandom_range(0, 4))
            0: rb = 0;
            1: rb = $urandom_range(1, 9);
            2: rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
         model(rf, ra, rb, mh, ml, mdz);
         run_op(rf, ra, rb, -1, rh, rl, rdz, lat, nb);
         chk($sformatf("rnd%0d_f%h_hi", n, rf), rh, mh);
         chk($sformatf("rnd%0d_f%h_lo", n, rf), rl, ml);
         chk($sformatf("rnd%0d_dz", n), rdz, mdz);
         chk($sformatf("rnd%0d_lat", n), lat, 33);
      end

      chk("no_flag_while_busy", ovl, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
